edp_store_buf: RTL
==================

// Module: edp_store_buf
// PURPOSE
//  Posted-write queue directly downstream of the EDP AR/cache-write path.
//  Accepts EDP store words (AR + VMA + halfword enables) and drains them in order to the cache/MBOX.
//  Forwards queued data to same-address loads, so the EBOX never reads stale cache data.
// PARAMETERS
//  DEPTH   4   entries; power of two, >=2
//  ADDR_W  23  store address width (VMA 13:35)
//  DATA_W  36  word width
// PORTS
//  CLK_EDP       in   1                 EDP clock; all state changes on its rising edge
//  EBOX_RESET_N  in   1                 synchronous, active-low reset
//  st_valid      in   1                 EDP presents a store
//  st_ready      out  1                 queue can accept this cycle
//  st_addr       in   ADDR_W            store address
//  st_data       in   DATA_W            store word (AR)
//  st_we         in   2                 {LH 0:17, RH 18:35} write enables
//  flush         in   1                 drain request; blocks new stores
//  flush_done    out  1                 flush high and queue empty
//  mem_req       out  1                 head entry valid toward cache
//  mem_addr      out  ADDR_W            head address
//  mem_data      out  DATA_W            head data
//  mem_we        out  2                 head halfword enables
//  mem_ack       in   1                 cache accepted head this cycle
//  ld_addr       in   ADDR_W            load probe address
//  ld_hit        out  1                 some queued entry matches ld_addr
//  ld_data       out  DATA_W            data of youngest match
//  ld_we         out  2                 halves valid in ld_data (youngest match)
//  count         out  $clog2(DEPTH+1)   occupied entries
//  mem_par       out  1                 head parity (only with STORE_BUF_PARITY_EN)
// BEHAVIOUR
//  - Reset (EBOX_RESET_N=0 at edge):
//    - drops all entries; pointers and count go to 0.
//    - Next cycle: mem_req=0, ld_hit=0, count=0, st_ready=1, flush_done=flush.
//    - Reset mid-drain loses queued stores; this is by design.
//  - Push:
//    - Occurs when st_valid & st_ready; st_ready = (count<DEPTH) & ~flush.
//    - Entry written at the tail; tail pointer wraps modulo DEPTH.
//    - Store with st_we=2'b00 is accepted and dropped: no entry, count unchanged.
//  - Drain:
//    - mem_req = (count!=0).
//    - mem_addr/mem_data/mem_we are driven from the head and held stable until mem_ack.
//    - Pop on mem_req & mem_ack; head pointer wraps. mem_ack while mem_req=0 is ignored.
//  - Latency: a pushed entry appears on mem_req/ld_hit the cycle after the push edge; no same-cycle bypass.
//  - Simultaneous push+pop: count unchanged, both pointers advance.
//    - Full + mem_ack: push still refused this cycle; st_ready rises next cycle.
//  - Ordering: strict FIFO; no coalescing of same-address stores.
//  - Forwarding (combinational):
//    - Compare ld_addr against all valid entries; select the youngest match (nearest the tail).
//    - ld_we = that entry's enables; ld_data = its data; no merging of older partial matches.
//    - No match: ld_hit=0, ld_data=0, ld_we=0.
//    - The entry being popped this cycle is still visible.
//  - flush: st_ready=0 while high; flush_done = flush & (count==0), combinational.
//  - count: 0..DEPTH, never exceeds DEPTH, never underflows.
// CONFIGURATION
//  STORE_BUF_PARITY_EN defined:
//    - Each entry stores parity = ^st_data captured at push; mem_par = head parity.
//    - Parity matches the FM_PARITY XOR convention.
//  STORE_BUF_PARITY_EN undefined: no parity storage; mem_par port absent.
// STRUCTURE
//  - Package store_buf_pkg: typedef struct tSBEntry {addr, data, we[0:1], par}.
//  - Package store_buf_pkg: constant SB_PTR_W = $clog2(DEPTH).
//  - Sub-module store_buf_fwd: youngest-match priority select over the valid vector,
//    ordered by the head/tail pointers.
//  - Top: entry array, head/tail/count registers, handshake logic.
// TESTING
//  1. Reset with 3 entries queued -> next cycle count=0, mem_req=0, ld_hit=0.
//  2. Push A=0o100 D=0o123456654321 we=11 -> next cycle mem_req=1, mem_addr=0o100;
//     mem_ack -> count 1->0.
//  3. Push 4 stores, mem_ack=0 -> st_ready=0.
//     Assert mem_ack with st_valid=1 -> that push refused; next cycle count=3, st_ready=1.
//  4. Push A=0o200 we=10 D1, then A=0o200 we=01 D2; ld_addr=0o200 -> ld_hit=1, ld_data=D2, ld_we=01.
//  5. flush=1 with 2 entries -> st_ready=0; ack twice -> flush_done=1 the cycle count reaches 0.
//  6. With STORE_BUF_PARITY_EN: push D=0o000000000001 -> mem_par=1; push D=0o000000000003 -> mem_par=0.

Source files
------------

// File: rtl/store_buf_pkg.sv
// Shared types and constants for the EDP posted-write store buffer.
package store_buf_pkg;

  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 23;
  localparam int SB_DATA_W = 36;
  localparam int SB_PTR_W  = $clog2(SB_DEPTH);

  // One queued store; we[0] is the left half (0:17), we[1] the right half (18:35).
  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [0:1]           we;
    logic                 par;
  } tSBEntry;

  // Plain XOR-reduce, the same sense the FM parity uses.
  function automatic logic sb_parity(input logic [SB_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/store_buf_fwd.sv
// Youngest-match select for load forwarding. Walks slots oldest to youngest
// starting at the head pointer, so the last valid match seen is the youngest.
module store_buf_fwd #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic [DEPTH-1:0] vld_i,
  input  logic [DEPTH-1:0] match_i,
  input  logic [PTR_W-1:0] head_i,
  output logic             hit_o,
  output logic [PTR_W-1:0] sel_o
);

  // Priority scan in age order; pointer arithmetic wraps because DEPTH is 2^n.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx   = '0;
    hit_o = 1'b0;
    sel_o = head_i;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if (vld_i[idx] && match_i[idx]) begin
        hit_o = 1'b1;
        sel_o = idx;
      end
    end
  end

endmodule

// File: rtl/edp_store_buf.sv
// EDP posted-write store buffer: in-order drain to cache/MBOX with
// combinational youngest-match forwarding to loads.
// Optional feature macro: STORE_BUF_PARITY_EN (per-entry parity, mem_par port).
module edp_store_buf
  import store_buf_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic                       CLK_EDP,
  input  logic                       EBOX_RESET_N,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic [1:0]                 st_we,
  input  logic                       flush,
  output logic                       flush_done,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data,
  output logic [1:0]                 mem_we,
  input  logic                       mem_ack,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_hit,
  output logic [DATA_W-1:0]          ld_data,
  output logic [1:0]                 ld_we,
`ifdef STORE_BUF_PARITY_EN
  output logic                       mem_par,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  tSBEntry          ent_q [DEPTH];
  tSBEntry          new_ent;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;
  logic [DEPTH-1:0] match;
  logic             fwd_hit;
  logic [PTR_W-1:0] fwd_sel;

  // Handshakes. A store with no enables is accepted but never queued.
  assign st_ready   = (cnt_q < CNT_W'(DEPTH)) & ~flush;
  assign do_push    = st_valid & st_ready & (|st_we);
  assign mem_req    = (cnt_q != '0);
  assign do_pop     = mem_req & mem_ack;
  assign flush_done = flush & (cnt_q == '0);
  assign count      = cnt_q;

  // Head entry drives the cache port; it only changes on a pop.
  assign mem_addr = ent_q[head_q].addr;
  assign mem_data = ent_q[head_q].data;
  assign mem_we   = ent_q[head_q].we;
`ifdef STORE_BUF_PARITY_EN
  assign mem_par  = ent_q[head_q].par;
`endif

  // Build the entry captured at the tail on a push.
  always_comb begin
    new_ent      = '0;
    new_ent.addr = st_addr;
    new_ent.data = st_data;
    new_ent.we   = st_we;
`ifdef STORE_BUF_PARITY_EN
    new_ent.par  = sb_parity(st_data);
`else
    new_ent.par  = 1'b0;
`endif
  end

  // Pointer/count/valid next state; a full buffer never sees a push, so a
  // pop and a push never collide on the same slot.
  always_comb begin
    head_d = head_q + PTR_W'(do_pop);
    tail_d = tail_q + PTR_W'(do_push);
    vld_d  = vld_q;
    if (do_pop)  vld_d[head_q] = 1'b0;
    if (do_push) vld_d[tail_q] = 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state with synchronous reset; queued stores are discarded.
  always_ff @(posedge CLK_EDP) begin
    if (!EBOX_RESET_N) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      vld_q  <= vld_d;
    end
  end

  // Entry storage needs no reset; the valid bits qualify it.
  always_ff @(posedge CLK_EDP) begin
    if (do_push) ent_q[tail_q] <= new_ent;
  end

  // Address compare per slot for forwarding.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign match[i] = (ent_q[i].addr == ld_addr);
  end

  store_buf_fwd #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd (
    .vld_i   (vld_q),
    .match_i (match),
    .head_i  (head_q),
    .hit_o   (fwd_hit),
    .sel_o   (fwd_sel)
  );

  // Forwarded result; zeroed on a miss.
  assign ld_hit  = fwd_hit;
  assign ld_data = fwd_hit ? ent_q[fwd_sel].data : '0;
  assign ld_we   = fwd_hit ? ent_q[fwd_sel].we   : 2'b00;

endmodule
